// File: rtl/hbus_rx_pkg.sv
// Shared types and helpers for the HyperBus receive word packer.
package hbus_rx_pkg;

    typedef logic [15:0] hbus_word_t;
    typedef logic [7:0]  hbus_byte_t;

    // Widest deserialiser factor supported; dq_par is widened to this before lane picking.
    localparam int HBUS_MAX_SAMPLES = 4;
    localparam int HBUS_DQ_MAX_W    = 8 * HBUS_MAX_SAMPLES;

    // Gathers the eight lane bits belonging to one sample slot into a byte.
    function automatic hbus_byte_t lane_byte(input logic [HBUS_DQ_MAX_W-1:0] dq,
                                             input int samples,
                                             input int s);
        hbus_byte_t b;
        b = '0;
        for (int l = 0; l < 8; l++) begin
            b[l] = dq[l * samples + s];
        end
        return b;
    endfunction

    // Only these deserialiser ratios are supported by the packing logic.
    function automatic bit samples_legal(input int samples);
        return (samples == 2) || (samples == 4);
    endfunction

endpackage

// File: rtl/hbus_rx_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rd_data.
// An extra pointer bit separates the full and empty cases.
module hbus_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
        $error("hbus_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doRead;
    logic             doWrite;

    assign level   = wrPtr_q - rdPtr_q;
    assign empty   = (wrPtr_q == rdPtr_q);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign doRead  = rd_en && !empty;
    assign doWrite = wr_en && (!full || doRead);
    assign rd_data = empty ? '0 : mem[rdPtr_q[AW-1:0]];

    // Pointer bookkeeping; a full FIFO still takes a write when the head leaves in the same cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hbus_rx_word_packer.sv
// Extracts DQ bytes at RWDS transitions from the deserialiser outputs,
// packs them big-endian into 16-bit words and queues them for the read path.
module hbus_rx_word_packer
    import hbus_rx_pkg::*;
#(
    parameter int SAMPLES    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          rx_en,
    input  logic                          clr_err,
    input  logic [8*SAMPLES-1:0]          dq_par,
    input  logic [SAMPLES-1:0]            rwds_par,
    output logic [15:0]                   rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          spacing_err
);

    if (!samples_legal(SAMPLES)) begin : gBadSamples
        $error("hbus_rx_word_packer: SAMPLES must be 2 or 4");
    end

    logic [HBUS_DQ_MAX_W-1:0] dqWide;
    logic       hist_q, hist_d;
    logic       lastTog_q, lastTog_d;
    logic       pend_q, pend_d;
    hbus_byte_t heldByte_q, heldByte_d;
    logic       overflow_q, spacingErr_q;

    logic       prevBit, prevTog, tog;
    hbus_byte_t curByte;
    logic       wordValid, extraWord, spacingSet;
    hbus_word_t wordData;

    logic       fifoFull, fifoEmpty, popEn, overflowSet;

    assign dqWide = HBUS_DQ_MAX_W'(dq_par);

    // Walk samples oldest to newest, flag RWDS edges and pair up the bytes found there.
    always_comb begin
        hist_d     = hist_q;
        lastTog_d  = lastTog_q;
        pend_d     = pend_q;
        heldByte_d = heldByte_q;
        wordValid  = 1'b0;
        wordData   = '0;
        extraWord  = 1'b0;
        spacingSet = 1'b0;
        prevBit    = hist_q;
        prevTog    = lastTog_q;
        tog        = 1'b0;
        curByte    = '0;
        if (rx_en) begin
            for (int s = SAMPLES - 1; s >= 0; s--) begin
                tog = rwds_par[s] ^ prevBit;
                if (tog && prevTog) spacingSet = 1'b1;
                if (tog) begin
                    curByte = lane_byte(dqWide, SAMPLES, s);
                    if (!pend_d) begin
                        heldByte_d = curByte;
                        pend_d     = 1'b1;
                    end else begin
                        pend_d = 1'b0;
                        if (!wordValid) begin
                            wordValid = 1'b1;
                            wordData  = {heldByte_d, curByte};
                        end else begin
                            extraWord = 1'b1;
                        end
                    end
                end
                prevBit = rwds_par[s];
                prevTog = tog;
            end
            hist_d    = rwds_par[0];
            lastTog_d = prevTog;
        end else begin
            pend_d    = 1'b0;
            hist_d    = 1'b0;
            lastTog_d = 1'b0;
        end
    end

    assign popEn       = rd_ready && !fifoEmpty;
    assign overflowSet = extraWord || (wordValid && fifoFull && !popEn);

    // Extraction state and sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hist_q       <= 1'b0;
            lastTog_q    <= 1'b0;
            pend_q       <= 1'b0;
            heldByte_q   <= '0;
            overflow_q   <= 1'b0;
            spacingErr_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            lastTog_q    <= lastTog_d;
            pend_q       <= pend_d;
            heldByte_q   <= heldByte_d;
            overflow_q   <= (overflow_q & ~clr_err) | overflowSet;
            spacingErr_q <= (spacingErr_q & ~clr_err) | spacingSet;
        end
    end

    hbus_rx_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk     (clk),
        .RST     (RST),
        .wr_en   (wordValid),
        .wr_data (wordData),
        .full    (fifoFull),
        .rd_en   (rd_ready),
        .rd_data (rd_data),
        .empty   (fifoEmpty),
        .level   (level)
    );

    assign rd_valid    = !fifoEmpty;
    assign overflow    = overflow_q;
    assign spacing_err = spacingErr_q;

endmodule

// File: tb/tb_hbus_rx_word_packer.sv
// Directed bench for the HyperBus receive word packer (SAMPLES=4, FIFO_DEPTH=8).
module tb_hbus_rx_word_packer;

   logic        clk;
   logic        RST;
   logic        rxEn;
   logic        clrErr;
   logic [31:0] dqPar;
   logic [3:0]  rwdsPar;
   logic [15:0] rdData;
   logic        rdValid;
   logic        rdReady;
   logic [3:0]  level;
   logic        overflow;
   logic        spacingErr;

   int testsRun;
   int failCount;

   hbus_rx_word_packer #(
      .SAMPLES    (4),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .RST         (RST),
      .rx_en       (rxEn),
      .clr_err     (clrErr),
      .dq_par      (dqPar),
      .rwds_par    (rwdsPar),
      .rd_data     (rdData),
      .rd_valid    (rdValid),
      .rd_ready    (rdReady),
      .level       (level),
      .overflow    (overflow),
      .spacing_err (spacingErr)
   );

   // Free-running divided clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lays out one byte per sample slot into the lane-major dq_par format.
   function automatic logic [31:0] makeDq(input logic [7:0] b3, input logic [7:0] b2,
                                          input logic [7:0] b1, input logic [7:0] b0);
      logic [7:0]  bs [4];
      logic [31:0] dq;
      bs[0] = b0;
      bs[1] = b1;
      bs[2] = b2;
      bs[3] = b3;
      dq = '0;
      for (int s = 0; s < 4; s++)
         for (int l = 0; l < 8; l++)
            dq[l * 4 + s] = bs[s][l];
      return dq;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic en, input logic clr, input logic rdy, input logic [3:0] rwds,
                                input logic [7:0] b3, input logic [7:0] b2,
                                input logic [7:0] b1, input logic [7:0] b0);
      rxEn    = en;
      clrErr  = clr;
      rdReady = rdy;
      rwdsPar = rwds;
      dqPar   = makeDq(b3, b2, b1, b0);
      @(posedge clk);
      #1;
   endtask

   logic [15:0] popExp [8];

   // Directed scenarios with hand-computed expectations.
   initial begin
      testsRun  = 0;
      failCount = 0;
      RST     = 1'b1;
      rxEn    = 1'b0;
      clrErr  = 1'b0;
      rdReady = 1'b0;
      rwdsPar = '0;
      dqPar   = '0;
      #12;
      checkOutput("reset_valid", 32'(rdValid), 32'h0);
      checkOutput("reset_level", 32'(level), 32'h0);
      checkOutput("reset_data", 32'(rdData), 32'h0);
      checkOutput("reset_ovf", 32'(overflow), 32'h0);
      checkOutput("reset_spc", 32'(spacingErr), 32'h0);
      RST = 1'b0;

      // Single word: 0xAB then 0xCD, each at a lone toggle on s=1.
      applyStimulus(1, 0, 0, 4'b0011, 8'h00, 8'h00, 8'hAB, 8'h00);
      checkOutput("single_half_valid", 32'(rdValid), 32'h0);
      applyStimulus(1, 0, 0, 4'b1100, 8'h00, 8'h00, 8'hCD, 8'h00);
      checkOutput("single_data", 32'(rdData), 32'hABCD);
      checkOutput("single_valid", 32'(rdValid), 32'h1);
      checkOutput("single_level", 32'(level), 32'h1);
      checkOutput("single_errs", {30'h0, overflow, spacingErr}, 32'h0);
      applyStimulus(0, 0, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("single_pop_level", 32'(level), 32'h0);

      // Continuous burst, toggles at s=3 and s=1 each cycle, drained as it arrives.
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 0, 1, 4'b1100, 8'(2 * k), 8'h00, 8'(2 * k + 1), 8'h00);
         checkOutput("burst_data", 32'(rdData), {16'h0, 8'(2 * k), 8'(2 * k + 1)});
         checkOutput("burst_level", 32'(level), 32'h1);
      end
      applyStimulus(0, 0, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("burst_drained", 32'(level), 32'h0);
      checkOutput("burst_ovf", 32'(overflow), 32'h0);
      checkOutput("burst_spc", 32'(spacingErr), 32'h0);

      // Overflow: nine words with no reader; the ninth is dropped.
      for (int k = 0; k < 9; k++) begin
         applyStimulus(1, 0, 0, 4'b1100, 8'(2 * k), 8'h00, 8'(2 * k + 1), 8'h00);
         if (k == 7) begin
            checkOutput("ovf_level8", 32'(level), 32'h8);
            checkOutput("ovf_not_yet", 32'(overflow), 32'h0);
         end
      end
      checkOutput("ovf_level", 32'(level), 32'h8);
      checkOutput("ovf_set", 32'(overflow), 32'h1);
      applyStimulus(0, 1, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("ovf_cleared", 32'(overflow), 32'h0);
      checkOutput("ovf_head", 32'(rdData), 32'h0001);

      // Full FIFO, word arrives while the head is popped: accepted without overflow.
      applyStimulus(1, 0, 1, 4'b1100, 8'hA0, 8'h00, 8'hA1, 8'h00);
      checkOutput("fullpop_level", 32'(level), 32'h8);
      checkOutput("fullpop_ovf", 32'(overflow), 32'h0);
      for (int i = 0; i < 7; i++) popExp[i] = {8'(2 * i + 2), 8'(2 * i + 3)};
      popExp[7] = 16'hA0A1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("pop_seq", 32'(rdData), 32'(popExp[i]));
         applyStimulus(0, 0, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      end
      checkOutput("pop_empty", 32'(rdValid), 32'h0);

      // Spacing violation at adjacent samples s=1,s=0, with a coincident clear that must lose.
      applyStimulus(1, 1, 0, 4'b0010, 8'h00, 8'h00, 8'h5A, 8'hA5);
      checkOutput("spc_set", 32'(spacingErr), 32'h1);
      checkOutput("spc_word", 32'(rdData), 32'h5AA5);
      applyStimulus(0, 1, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("spc_cleared", 32'(spacingErr), 32'h0);
      checkOutput("spc_popped", 32'(level), 32'h0);

      // Odd byte count, then rx_en drop discards the pending byte.
      applyStimulus(1, 0, 0, 4'b1100, 8'h31, 8'h00, 8'h32, 8'h00);
      applyStimulus(1, 0, 0, 4'b1111, 8'h33, 8'h00, 8'h00, 8'h00);
      checkOutput("odd_level", 32'(level), 32'h1);
      applyStimulus(0, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(1, 0, 0, 4'b1100, 8'h11, 8'h00, 8'h22, 8'h00);
      checkOutput("odd_level2", 32'(level), 32'h2);
      checkOutput("odd_head", 32'(rdData), 32'h3132);
      applyStimulus(0, 0, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("odd_second", 32'(rdData), 32'h1122);

      // Asynchronous reset mid-burst empties everything without a clock edge.
      applyStimulus(1, 0, 0, 4'b1100, 8'h44, 8'h00, 8'h55, 8'h00);
      checkOutput("pre_rst_level", 32'(level), 32'h2);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("rst_valid", 32'(rdValid), 32'h0);
      checkOutput("rst_level", 32'(level), 32'h0);
      checkOutput("rst_data", 32'(rdData), 32'h0);
      @(posedge clk);
      #2;
      RST = 1'b0;
      rxEn = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
